// File: rtl/matmul_mac_sequencer_if.sv
// Control/strobe bundle between the matmul sequencer and its surroundings.
//   start, abort          : run control from the top-level controller
//   busy, done            : run status back to the controller
//   rd_en, a_addr, b_addr : operand read requests to the A and B memories
//   mac_en, mac_clr       : MAC accumulate / load-product strobes
//   c_we, c_addr          : result write-back to the C memory
// The master modport is the sequencer side; the slave modport is the environment.
interface matmul_mac_sequencer_if #(
    parameter int unsigned AW = 6
);
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] a_addr;
    logic [AW-1:0] b_addr;
    logic          mac_en;
    logic          mac_clr;
    logic          c_we;
    logic [AW-1:0] c_addr;

    modport master (
        input  start, abort,
        output busy, done, rd_en, a_addr, b_addr, mac_en, mac_clr, c_we, c_addr
    );

    modport slave (
        output start, abort,
        input  busy, done, rd_en, a_addr, b_addr, mac_en, mac_clr, c_we, c_addr
    );
endinterface

// File: rtl/matmul_mac_sequencer.sv
// Sequences C = A*B (N x N) over one shared MAC: issues one A/B operand read
// per cycle in i/j/k order, delays a tag through the memory read latency to
// drive the MAC strobes, then raises the C write one cycle later.
// Ports:
//   CLK  : clock, rising edge
//   RST  : asynchronous active-low reset
//   bus  : matmul_mac_sequencer_if.master (start/abort in; busy, done,
//          rd_en, a_addr, b_addr, mac_en, mac_clr, c_we, c_addr out)
module matmul_mac_sequencer #(
    parameter int unsigned N      = 3,
    parameter int unsigned AW     = 6,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                          CLK,
    input  logic                          RST,
    matmul_mac_sequencer_if.master        bus
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW = $clog2(RD_LAT + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
    localparam logic [AW-1:0] N_AW     = AW'(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // first/last are stored already qualified by valid so they can be
    // driven straight out of the flops.
    typedef struct packed {
        logic          valid;
        logic          first;
        logic          last;
        logic [AW-1:0] cidx;
    } tag_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        i_q, i_d, j_q, j_d, k_q, k_d;
    logic [AW-1:0]        a_addr_q, a_addr_d;
    logic [AW-1:0]        b_addr_q, b_addr_d;
    logic [AW-1:0]        c_addr_q, c_addr_d;
    tag_t [RD_LAT:0]      pipe_q, pipe_d;
    logic                 c_we_q, c_we_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 kill;
    logic                 last_issue;
    logic                 pending;
    logic                 issue;

    // Next-state, counter advance and pipeline shift.
    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        pipe_d     = '0;
        c_we_d     = 1'b0;
        c_addr_d   = c_addr_q;
        a_addr_d   = '0;
        b_addr_d   = '0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        issue      = 1'b0;

        kill       = (state_q != IDLE) && bus.abort;
        last_issue = (i_q == LAST_IDX) && (j_q == LAST_IDX) && (k_q == LAST_IDX);

        // Anything still in flight toward the MAC or the C write stage.
        pending = pipe_q[RD_LAT].last;
        for (int unsigned n = 0; n < RD_LAT; n++) begin
            pending = pending | pipe_q[PW'(n)].valid;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (k_q == LAST_IDX) begin
                    k_d = '0;
                    if (j_q == LAST_IDX) begin
                        j_d = '0;
                        i_d = (i_q == LAST_IDX) ? '0 : i_q + CW'(1);
                    end else begin
                        j_d = j_q + CW'(1);
                    end
                end else begin
                    k_d = k_q + CW'(1);
                end
                if (last_issue) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!pending) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                i_d     = '0;
                j_d     = '0;
                k_d     = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (kill) begin
            state_d = IDLE;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
        end

        // Issue stage: the registered addresses/tag belong to the counters
        // that will be current next cycle.
        issue    = (state_d == ISSUE);
        a_addr_d = AW'(i_d) * N_AW + AW'(k_d);
        b_addr_d = AW'(k_d) * N_AW + AW'(j_d);

        pipe_d[0].valid = issue;
        pipe_d[0].first = issue && (k_d == '0);
        pipe_d[0].last  = issue && (k_d == LAST_IDX);
        pipe_d[0].cidx  = AW'(i_d) * N_AW + AW'(j_d);

        for (int unsigned n = 1; n <= RD_LAT; n++) begin
            pipe_d[PW'(n)] = kill ? '0 : pipe_q[PW'(n - 1)];
        end

        // Write stage trails the MAC stage by one cycle (registered MAC output).
        c_we_d = !kill && pipe_q[RD_LAT].last;
        if (c_we_d) begin
            c_addr_d = pipe_q[RD_LAT].cidx;
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            c_addr_q <= '0;
            pipe_q   <= '0;
            c_we_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            a_addr_q <= a_addr_d;
            b_addr_q <= b_addr_d;
            c_addr_q <= c_addr_d;
            pipe_q   <= pipe_d;
            c_we_q   <= c_we_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rd_en   = pipe_q[0].valid;
    assign bus.a_addr  = a_addr_q;
    assign bus.b_addr  = b_addr_q;
    assign bus.mac_en  = pipe_q[RD_LAT].valid;
    assign bus.mac_clr = pipe_q[RD_LAT].first;
    assign bus.c_we    = c_we_q;
    assign bus.c_addr  = c_addr_q;

endmodule

// File: tb/tb_matmul_mac_sequencer.sv
// Scoreboard bench: u0 is N=3/RD_LAT=1 with behavioural A/B/C memories and MAC,
// u1 is N=2/RD_LAT=3. Stimulus pushes cycle-stamped expected events; a negedge
// monitor pops and compares whenever a strobe is seen.
module tb_matmul_mac_sequencer;

    localparam int BIG = 32'h3fff_ffff;

    typedef struct {
        int cyc;
        int v0;
        int v1;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;

    ev_t rdq [2][$];
    ev_t macq[2][$];
    ev_t cwq [2][$];
    ev_t dnq [2][$];

    int mem_a[64];
    int mem_b[64];
    int mem_c[64];
    int a_d, b_d, acc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    matmul_mac_sequencer_if #(.AW(6)) if0 ();
    matmul_mac_sequencer_if #(.AW(6)) if1 ();

    matmul_mac_sequencer #(.N(3), .AW(6), .RD_LAT(1)) u0 (
        .CLK (clk),
        .RST (rst_n),
        .bus (if0)
    );

    matmul_mac_sequencer #(.N(2), .AW(6), .RD_LAT(3)) u1 (
        .CLK (clk),
        .RST (rst_n),
        .bus (if1)
    );

    // Behavioural operand memories (1-cycle read), MAC and C memory for u0.
    always @(posedge clk) begin
        if (if0.rd_en) begin
            a_d <= mem_a[if0.a_addr];
            b_d <= mem_b[if0.b_addr];
        end
        if (if0.mac_en) begin
            acc <= if0.mac_clr ? a_d * b_d : acc + a_d * b_d;
        end
        if (if0.c_we) begin
            mem_c[if0.c_addr] <= acc;
        end
    end

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Expected events of one run started (start sampled) in cycle s; events
    // after cycle lim are suppressed (abort sampled at the end of cycle lim).
    function automatic void push_run(input int d, input int s, input int n, input int lat, input int lim);
        ev_t e;
        for (int idx = 0; idx < n * n * n; idx++) begin
            int i, j, k, ic;
            i  = idx / (n * n);
            j  = (idx / n) % n;
            k  = idx % n;
            ic = s + 1 + idx;
            if (ic <= lim) begin
                e = '{ic, i * n + k, k * n + j};
                rdq[d].push_back(e);
            end
            if (ic + lat <= lim) begin
                e = '{ic + lat, (k == 0) ? 1 : 0, 0};
                macq[d].push_back(e);
            end
            if (k == n - 1 && ic + lat + 1 <= lim) begin
                e = '{ic + lat + 1, i * n + j, 0};
                cwq[d].push_back(e);
            end
        end
        if (s + n * n * n + lat + 2 <= lim) begin
            e = '{s + n * n * n + lat + 2, 0, 0};
            dnq[d].push_back(e);
        end
    endfunction

    task automatic mon(input int d, input logic rd, input int a, input int b, input logic me,
                       input logic mc, input logic cw, input int ca, input logic dn);
        ev_t   e;
        string p;
        p = (d == 0) ? "u0_" : "u1_";
        while (rdq[d].size() > 0 && rdq[d][0].cyc < cyc) begin
            e = rdq[d].pop_front();
            chk({p, "rd_missing"}, cyc, e.cyc);
        end
        while (macq[d].size() > 0 && macq[d][0].cyc < cyc) begin
            e = macq[d].pop_front();
            chk({p, "mac_missing"}, cyc, e.cyc);
        end
        while (cwq[d].size() > 0 && cwq[d][0].cyc < cyc) begin
            e = cwq[d].pop_front();
            chk({p, "cwe_missing"}, cyc, e.cyc);
        end
        while (dnq[d].size() > 0 && dnq[d][0].cyc < cyc) begin
            e = dnq[d].pop_front();
            chk({p, "done_missing"}, cyc, e.cyc);
        end
        if (rd) begin
            if (rdq[d].size() == 0) chk({p, "rd_extra"}, cyc, -1);
            else begin
                e = rdq[d].pop_front();
                chk({p, "rd_cyc"}, cyc, e.cyc);
                chk({p, "a_addr"}, a, e.v0);
                chk({p, "b_addr"}, b, e.v1);
            end
        end
        if (me) begin
            if (macq[d].size() == 0) chk({p, "mac_extra"}, cyc, -1);
            else begin
                e = macq[d].pop_front();
                chk({p, "mac_cyc"}, cyc, e.cyc);
                chk({p, "mac_clr"}, int'(mc), e.v0);
            end
        end
        if (cw) begin
            if (cwq[d].size() == 0) chk({p, "cwe_extra"}, cyc, -1);
            else begin
                e = cwq[d].pop_front();
                chk({p, "cwe_cyc"}, cyc, e.cyc);
                chk({p, "c_addr"}, ca, e.v0);
            end
        end
        if (dn) begin
            if (dnq[d].size() == 0) chk({p, "done_extra"}, cyc, -1);
            else begin
                e = dnq[d].pop_front();
                chk({p, "done_cyc"}, cyc, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, if0.rd_en, int'(if0.a_addr), int'(if0.b_addr), if0.mac_en, if0.mac_clr,
                if0.c_we, int'(if0.c_addr), if0.done);
            mon(1, if1.rd_en, int'(if1.a_addr), int'(if1.b_addr), if1.mac_en, if1.mac_clr,
                if1.c_we, int'(if1.c_addr), if1.done);
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_u0_outs"}, int'({if0.busy, if0.done, if0.rd_en, if0.mac_en, if0.mac_clr,
                                     if0.c_we, if0.a_addr, if0.b_addr, if0.c_addr}), 0);
        chk({tag, "_u1_outs"}, int'({if1.busy, if1.done, if1.rd_en, if1.mac_en, if1.mac_clr,
                                     if1.c_we, if1.a_addr, if1.b_addr, if1.c_addr}), 0);
    endtask

    initial begin
        int s;
        rst_n     = 1'b0;
        if0.start = 1'b0;
        if0.abort = 1'b0;
        if1.start = 1'b0;
        if1.abort = 1'b0;
        for (int t = 0; t < 64; t++) begin
            mem_a[t] = (t < 9 && (t / 3) == (t % 3)) ? 1 : 0;
            mem_b[t] = t + 1;
            mem_c[t] = 0;
        end

        repeat (3) @(negedge clk);
        chk_quiet("reset");
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk_quiet("idle");
        end

        // Normal runs on both instances, plus a stray start mid-run on u0.
        s = cyc;
        if0.start = 1'b1;
        if1.start = 1'b1;
        push_run(0, s, 3, 1, BIG);
        push_run(1, s, 2, 3, BIG);
        @(negedge clk);
        if0.start = 1'b0;
        if1.start = 1'b0;
        chk("u0_busy_first", int'(if0.busy), 1);
        wait_until(s + 10);
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        wait_until(s + 13);
        chk("u1_busy_at_done", int'(if1.busy), 1);
        @(negedge clk);
        chk("u1_busy_after", int'(if1.busy), 0);
        wait_until(s + 30);
        chk("u0_busy_at_done", int'(if0.busy), 1);
        @(negedge clk);
        chk("u0_busy_after", int'(if0.busy), 0);
        wait_until(s + 34);
        for (int t = 0; t < 9; t++) begin
            chk($sformatf("c_mem[%0d]", t), mem_c[t], t + 1);
        end

        // Abort at cycle 15 of a run, then idle long enough to expose leaks.
        @(negedge clk);
        s = cyc;
        if0.start = 1'b1;
        push_run(0, s, 3, 1, s + 15);
        @(negedge clk);
        if0.start = 1'b0;
        wait_until(s + 15);
        chk("abort_busy_before", int'(if0.busy), 1);
        if0.abort = 1'b1;
        @(negedge clk);
        if0.abort = 1'b0;
        chk("abort_busy_after", int'(if0.busy), 0);
        wait_until(s + 40);

        // start and abort together in IDLE: the run must proceed.
        s = cyc;
        if0.start = 1'b1;
        if0.abort = 1'b1;
        push_run(0, s, 3, 1, BIG);
        @(negedge clk);
        if0.start = 1'b0;
        if0.abort = 1'b0;
        wait_until(s + 35);

        // start held high: second run sampled in the IDLE cycle after DONE.
        s = cyc;
        if0.start = 1'b1;
        push_run(0, s, 3, 1, BIG);
        push_run(0, s + 31, 3, 1, BIG);
        wait_until(s + 31);
        chk("held_idle_gap", int'(if0.busy), 0);
        @(negedge clk);
        chk("held_rerun_busy", int'(if0.busy), 1);
        wait_until(s + 40);
        if0.start = 1'b0;
        wait_until(s + 70);

        for (int d = 0; d < 2; d++) begin
            chk($sformatf("u%0d_rd_left", d), rdq[d].size(), 0);
            chk($sformatf("u%0d_mac_left", d), macq[d].size(), 0);
            chk($sformatf("u%0d_cwe_left", d), cwq[d].size(), 0);
            chk($sformatf("u%0d_done_left", d), dnq[d].size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
